// File: rtl/mem_arbiter.sv
// Two-port req/ack arbiter in front of a single-port memory with fixed wait states.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned WAIT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          last_q;

    logic          elig0, elig1;
    logic          grant;
    logic          start;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // In DONE the acked requester still holds req for this cycle, so it is masked out.
    always_comb begin
        elig0 = req0;
        elig1 = req1;
        if (state_q == StDone) begin
            if (owner) elig1 = 1'b0;
            else       elig0 = 1'b0;
        end
`ifdef MEM_ARB_RR_EN
        if (elig0 && elig1) grant = ~last_q;
        else                grant = elig1;
`else
        grant = ~elig0;
`endif
        start     = (elig0 | elig1) && (state_q == StIdle || state_q == StDone);
        sel_we    = grant ? we1    : we0;
        sel_addr  = grant ? addr1  : addr0;
        sel_wdata = grant ? wdata1 : wdata0;
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last;
    assign unused_last = last_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata     <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            owner     <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            unique case (state_q)
                StIdle: ;
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (mem_rd) rdata <= mem_rdata;
                        mem_rd  <= 1'b0;
                        mem_wr  <= 1'b0;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: begin
                    last_q <= owner;
                    if (!start) begin
                        state_q <= StIdle;
                        busy    <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
            // Shared by IDLE and DONE so back-to-back grants skip the IDLE bubble.
            if (start) begin
                state_q   <= StAccess;
                owner     <= grant;
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                mem_rd    <= ~sel_we;
                mem_wr    <= sel_we;
                cnt_q     <= 4'(WAIT);
                busy      <= 1'b1;
            end
        end
    end

endmodule
